// File: rtl/shift_amt_regs.sv
// shift_amt_regs: Avalon-MM register block for per-channel pitch-shift amounts.
// Software writes shadow values, requests a commit, and the commit is applied
// on the next audio sample boundary. Live values either jump to the target or
// slew toward it one bounded step per sample. An interrupt flags settling.

module shift_amt_regs #(
  parameter int NUM_CH      = 2,
  parameter int SHIFT_W     = 8,
  parameter int ADDR_W      = 4,
  parameter int RAMP_STEP   = 1,
  parameter int RESET_SHIFT = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        avs_chipselect,
  input  logic [ADDR_W-1:0]           avs_address,
  input  logic                        avs_read,
  input  logic                        avs_write,
  input  logic [31:0]                 avs_writedata,
  output logic [31:0]                 avs_readdata,
  input  logic                        sample_tick,
  output logic [NUM_CH*SHIFT_W-1:0]   shift_amt_out,
  output logic [NUM_CH-1:0]           ramping,
  output logic                        irq
);

  // Reset value and ramp step, sized to one channel.
  localparam logic [SHIFT_W-1:0] RST_V  = SHIFT_W'(RESET_SHIFT);
  localparam logic [SHIFT_W-1:0] STEP_V = SHIFT_W'(RAMP_STEP);

  // Fixed register word addresses.
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);

  // Control / status state.
  logic r_pending;
  logic r_ramp_en;
  logic r_irq_en;
  logic r_settling;
  logic r_done;
  logic [31:0] r_readdata;

  // Bus decode.
  logic w_wr;
  logic w_rd;
  logic w_wr_ctrl;
  logic w_wr_status;
  logic w_commit_req;
  logic w_done_clr;

  // Commit / settle bookkeeping.
  logic w_apply;
  logic w_settle_next;
  logic w_done_set;

  // Per-channel views gathered from the generate blocks.
  logic [NUM_CH-1:0][SHIFT_W-1:0] w_shadow_all;
  logic [NUM_CH-1:0][SHIFT_W-1:0] w_live_all;
  logic [NUM_CH-1:0]              w_eq_next;
  logic [NUM_CH-1:0]              w_ramping;

  // Read mux output.
  logic [31:0] w_rdata;

  // Only a few write-data bits are meaningful; the rest are deliberately dropped.
  logic w_unused;
  assign w_unused = &{1'b0, avs_writedata};

  assign w_wr         = avs_chipselect & avs_write;
  assign w_rd         = avs_chipselect & avs_read;
  assign w_wr_ctrl    = w_wr & (avs_address == A_CTRL);
  assign w_wr_status  = w_wr & (avs_address == A_STATUS);
  assign w_commit_req = w_wr_ctrl & avs_writedata[0];
  assign w_done_clr   = w_wr_status & avs_writedata[2];

  // A commit is applied only from the pending flag as it stood before this
  // cycle, so a COMMIT write coinciding with a tick waits for the next tick.
  assign w_apply = sample_tick & r_pending;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi = gi + 1) begin : g_ch
      localparam logic [ADDR_W-1:0] SH_A = ADDR_W'(2 + gi);

      logic [SHIFT_W-1:0] r_shadow;
      logic [SHIFT_W-1:0] r_target;
      logic [SHIFT_W-1:0] r_live;

      logic               w_up;
      logic [SHIFT_W-1:0] w_diff;
      logic [SHIFT_W-1:0] w_delta;
      logic [SHIFT_W-1:0] w_stepped;
      logic [SHIFT_W-1:0] w_live_next;
      logic [SHIFT_W-1:0] w_target_next;

      // Ramp step: move toward the current target by at most STEP_V, never
      // past it. Since delta <= |target-live| there is no wrap in either direction.
      assign w_up      = (r_target > r_live);
      assign w_diff    = w_up ? (r_target - r_live) : (r_live - r_target);
      assign w_delta   = (w_diff < STEP_V) ? w_diff : STEP_V;
      assign w_stepped = w_up ? (r_live + w_delta) : (r_live - w_delta);

      // Live follows the target as it was before this tick's commit.
      assign w_live_next   = !sample_tick ? r_live :
                             (r_ramp_en ? w_stepped : r_target);
      assign w_target_next = w_apply ? r_shadow : r_target;

      assign w_eq_next[gi]    = (w_live_next == w_target_next);
      assign w_ramping[gi]    = (r_live != r_target);
      assign w_shadow_all[gi] = r_shadow;
      assign w_live_all[gi]   = r_live;
      assign shift_amt_out[gi*SHIFT_W +: SHIFT_W] = r_live;

      // Shadow register: software-writable at any time, low SHIFT_W bits kept.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_shadow <= RST_V;
        end else if (w_wr && (avs_address == SH_A)) begin
          r_shadow <= avs_writedata[SHIFT_W-1:0];
        end
      end

      // Target and live registers change only on sample ticks.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_target <= RST_V;
          r_live   <= RST_V;
        end else begin
          r_target <= w_target_next;
          r_live   <= w_live_next;
        end
      end
    end
  endgenerate

  assign ramping = w_ramping;

  // Settling completes on a tick after which every channel has reached its target.
  assign w_settle_next = r_settling | w_apply;
  assign w_done_set    = sample_tick & w_settle_next & (&w_eq_next);

  // Pending commit flag; a new COMMIT write overrides the clear from an apply.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
    end else if (w_commit_req) begin
      r_pending <= 1'b1;
    end else if (w_apply) begin
      r_pending <= 1'b0;
    end
  end

  // Control bits written through CTRL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ramp_en <= 1'b0;
      r_irq_en  <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_ramp_en <= avs_writedata[1];
      r_irq_en  <= avs_writedata[2];
    end
  end

  // Settling tracker: armed by a commit, cleared when done fires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_settling <= 1'b0;
    end else if (sample_tick) begin
      r_settling <= w_done_set ? 1'b0 : w_settle_next;
    end
  end

  // Sticky done flag; a set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
    end else if (w_done_set) begin
      r_done <= 1'b1;
    end else if (w_done_clr) begin
      r_done <= 1'b0;
    end
  end

  // Read mux: unmapped addresses and unused bits return zero.
  always_comb begin
    w_rdata = 32'd0;
    if (avs_address == A_CTRL) begin
      w_rdata[2:0] = {r_irq_en, r_ramp_en, r_pending};
    end else if (avs_address == A_STATUS) begin
      w_rdata[2:0] = {r_done, |w_ramping, r_pending};
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (avs_address == ADDR_W'(2 + c)) begin
        w_rdata[SHIFT_W-1:0] = w_shadow_all[c];
      end
      if (avs_address == ADDR_W'(2 + NUM_CH + c)) begin
        w_rdata[SHIFT_W-1:0] = w_live_all[c];
      end
    end
  end

  // Registered read data, one-cycle latency, held until the next read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
    end else if (w_rd) begin
      r_readdata <= w_rdata;
    end
  end

  assign avs_readdata = r_readdata;
  assign irq          = r_done & r_irq_en;

endmodule
